// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch/jump predictor sitting between fetch and execute. A direct-mapped
//   branch target buffer (BTB) with 2-bit saturating direction counters gives
//   fetch a same-cycle taken/target prediction. The execute stage resolves each
//   control-flow instruction against the prediction it carried down the pipe.
//   A wrong prediction raises a registered one-cycle redirect pulse.
//   Saturating counters track branches and mispredictions.
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous active-low reset, clears all state
//   fetch_pc            PC being fetched this cycle
//   pred_taken          combinational taken prediction for fetch_pc
//   pred_target         combinational predicted target (0 when not taken)
//   resolve_valid       execute holds a control-flow instruction this cycle
//   resolve_uncond      instruction is an unconditional jump (j/jal/jr)
//   resolve_pc          PC of the resolving instruction
//   resolve_taken       actual direction
//   resolve_target      actual target
//   resolve_pred_taken  prediction carried with the instruction
//   resolve_pred_target predicted target carried with the instruction
//   mispredict          registered one-cycle mispredict pulse
//   redirect_pc         registered correct next PC, valid with mispredict
//   branch_count        saturating count of resolved control-flow instructions
//   mispredict_count    saturating count of mispredictions
module branch_predict_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 resolve_valid,
  input  logic                 resolve_uncond,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic                 resolve_taken,
  input  logic [PC_WIDTH-1:0]  resolve_target,
  input  logic                 resolve_pred_taken,
  input  logic [PC_WIDTH-1:0]  resolve_pred_target,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // BTB storage, all in flops so every entry can be reset in one cycle
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    uncond_q;
  logic [1:0]          ctr_q    [DEPTH];
  logic [TAG_BITS-1:0] tag_q    [DEPTH];
  logic [PC_WIDTH-1:0] target_q [DEPTH];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;

  logic [INDEX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0]   res_tag;
  logic                  res_hit;
  logic                  res_miss;

  // Only the index and tag fields of the PCs take part in the BTB; the
  // remaining upper bits are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, fetch_pc, resolve_pc};

  assign fetch_idx = fetch_pc[INDEX_BITS-1:0];
  assign fetch_tag = fetch_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign res_idx   = resolve_pc[INDEX_BITS-1:0];
  assign res_tag   = resolve_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];

  // Lookup reads the registered contents only, so an update on the same
  // edge is not visible until the following cycle.
  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && (uncond_q[fetch_idx] || ctr_q[fetch_idx][1]);
    pred_target = pred_taken ? target_q[fetch_idx] : '0;
  end

  // A taken branch with the right direction but a stale target (e.g. a jr
  // whose register changed) still counts as a miss.
  always_comb begin
    res_hit  = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    res_miss = (resolve_taken != resolve_pred_taken) ||
               (resolve_taken && (resolve_target != resolve_pred_target));
  end

  // BTB update. Direction training uses resolve_taken alone, so an
  // unconditional jump reported as not taken trains as not taken. Not-taken
  // branches that miss in the BTB never allocate, which keeps entries for
  // branches that actually redirect fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      uncond_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i]    <= CTR_WEAK_NT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (resolve_valid) begin
      if (res_hit) begin
        uncond_q[res_idx] <= resolve_uncond;
        if (resolve_taken) begin
          target_q[res_idx] <= resolve_target;
          if (ctr_q[res_idx] != 2'b11) begin
            ctr_q[res_idx] <= ctr_q[res_idx] + 2'b01;
          end
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - 2'b01;
        end
      end else if (resolve_taken) begin
        valid_q[res_idx]  <= 1'b1;
        uncond_q[res_idx] <= resolve_uncond;
        tag_q[res_idx]    <= res_tag;
        target_q[res_idx] <= resolve_target;
        ctr_q[res_idx]    <= CTR_WEAK_T;
      end
    end
  end

  // Redirect pulse. redirect_pc holds between resolves so flush logic can
  // sample it any time mispredict is high; the fall-through PC wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (resolve_valid) begin
      mispredict  <= res_miss;
      redirect_pc <= resolve_taken ? resolve_target
                                   : resolve_pc + PC_WIDTH'(1);
    end else begin
      mispredict <= 1'b0;
    end
  end

  // Performance counters stick at all-ones rather than wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve_valid) begin
      if (branch_count != CNT_MAX) begin
        branch_count <= branch_count + CNT_WIDTH'(1);
      end
      if (res_miss && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
//   Directed bench for branch_predict_unit. A default-parameter instance
//   carries the functional scenarios. A second instance with 4-bit
//   performance counters shares the same stimulus and exercises counter
//   saturation.
module tb_branch_predict_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid = 1'b0;
  logic        resolve_uncond = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        resolve_pred_taken = 1'b0;
  logic [31:0] resolve_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  logic        sm_pred_taken;
  logic [31:0] sm_pred_target;
  logic        sm_mispredict;
  logic [31:0] sm_redirect_pc;
  logic [3:0]  sm_branch_count;
  logic [3:0]  sm_mispredict_count;

  int pass_count = 0;
  int check_count = 0;

  branch_predict_unit dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_uncond(resolve_uncond),
    .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
    .resolve_pred_target(resolve_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.CNT_WIDTH(4)) dut_small (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(sm_pred_taken), .pred_target(sm_pred_target),
    .resolve_valid(resolve_valid), .resolve_uncond(resolve_uncond),
    .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
    .resolve_pred_target(resolve_pred_target),
    .mispredict(sm_mispredict), .redirect_pc(sm_redirect_pc),
    .branch_count(sm_branch_count), .mispredict_count(sm_mispredict_count)
  );

  always #5 clock = ~clock;

  // Present one resolve for a single edge, then sample 1 time unit later
  task automatic do_resolve(input logic uncond, input logic [31:0] pc,
                            input logic taken, input logic [31:0] target,
                            input logic ptaken, input logic [31:0] ptarget);
    if (uncond && !taken) begin
      check_count++;
      $display("[TB] FAIL illegal_stimulus: uncond=1 taken=0 at pc %h", pc);
    end
    resolve_valid       = 1'b1;
    resolve_uncond      = uncond;
    resolve_pc          = pc;
    resolve_taken       = taken;
    resolve_target      = target;
    resolve_pred_taken  = ptaken;
    resolve_pred_target = ptarget;
    @(posedge clock);
    #1;
    resolve_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    fetch_pc = 32'h40;
    #1;
    check_count++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      $display("[TB] FAIL reset_pred: got %b/%h expected 0/0", pred_taken, pred_target);
    end else pass_count++;
    check_count++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
      $display("[TB] FAIL reset_redirect: got %b/%h expected 0/0", mispredict, redirect_pc);
    end else pass_count++;
    check_count++;
    if (branch_count !== 16'h0 || mispredict_count !== 16'h0) begin
      $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end else pass_count++;
    @(negedge clock);
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_allocate();
    do_resolve(1'b0, 32'h40, 1'b1, 32'h50, 1'b0, 32'h0);
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h50) begin
      $display("[TB] FAIL alloc_redirect: got %b/%h expected 1/00000050", mispredict, redirect_pc);
    end else pass_count++;
    check_count++;
    if (mispredict_count !== 16'd1 || branch_count !== 16'd1) begin
      $display("[TB] FAIL alloc_counts: got %0d/%0d expected 1/1", mispredict_count, branch_count);
    end else pass_count++;
    fetch_pc = 32'h40;
    #1;
    check_count++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h50) begin
      $display("[TB] FAIL alloc_lookup: got %b/%h expected 1/00000050", pred_taken, pred_target);
    end else pass_count++;
    idle_cycle();
    check_count++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h50) begin
      $display("[TB] FAIL pulse_end_hold: got %b/%h expected 0/00000050", mispredict, redirect_pc);
    end else pass_count++;
  endtask

  task automatic test_hysteresis();
    fetch_pc = 32'h40;
    // 10 -> 01
    do_resolve(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h50);
    check_count++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      $display("[TB] FAIL hyst_weak_nt: got %b/%h expected 0/0", pred_taken, pred_target);
    end else pass_count++;
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h41) begin
      $display("[TB] FAIL hyst_nt_redirect: got %b/%h expected 1/00000041", mispredict, redirect_pc);
    end else pass_count++;
    // 01 -> 10 -> 11
    do_resolve(1'b0, 32'h40, 1'b1, 32'h50, 1'b0, 32'h0);
    do_resolve(1'b0, 32'h40, 1'b1, 32'h50, 1'b1, 32'h50);
    check_count++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b0) begin
      $display("[TB] FAIL hyst_strong_t: got pred %b misp %b expected 1/0", pred_taken, mispredict);
    end else pass_count++;
    // 11 -> 10 still predicts taken
    do_resolve(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h50);
    check_count++;
    if (pred_taken !== 1'b1) begin
      $display("[TB] FAIL hyst_11_to_10: got %b expected 1", pred_taken);
    end else pass_count++;
    // 10 -> 01 -> 00 -> stays 00
    do_resolve(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h50);
    do_resolve(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    do_resolve(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    check_count++;
    if (pred_taken !== 1'b0) begin
      $display("[TB] FAIL hyst_floor: got %b expected 0", pred_taken);
    end else pass_count++;
    // one taken from 00 reaches only 01, so prediction stays not-taken
    do_resolve(1'b0, 32'h40, 1'b1, 32'h50, 1'b0, 32'h0);
    check_count++;
    if (pred_taken !== 1'b0) begin
      $display("[TB] FAIL hyst_00_to_01: got %b expected 0", pred_taken);
    end else pass_count++;
  endtask

  task automatic test_jr_target();
    do_resolve(1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 32'h0);
    do_resolve(1'b1, 32'h20, 1'b1, 32'h180, 1'b1, 32'h100);
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h180) begin
      $display("[TB] FAIL jr_redirect: got %b/%h expected 1/00000180", mispredict, redirect_pc);
    end else pass_count++;
    fetch_pc = 32'h20;
    #1;
    check_count++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin
      $display("[TB] FAIL jr_lookup: got %b/%h expected 1/00000180", pred_taken, pred_target);
    end else pass_count++;
  endtask

  task automatic test_alias();
    do_resolve(1'b0, 32'h013, 1'b1, 32'h033, 1'b0, 32'h0);
    fetch_pc = 32'h013;
    #1;
    check_count++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h033) begin
      $display("[TB] FAIL alias_first: got %b/%h expected 1/00000033", pred_taken, pred_target);
    end else pass_count++;
    do_resolve(1'b0, 32'h113, 1'b1, 32'h133, 1'b0, 32'h0);
    fetch_pc = 32'h013;
    #1;
    check_count++;
    if (pred_taken !== 1'b0) begin
      $display("[TB] FAIL alias_evicted: got %b expected 0", pred_taken);
    end else pass_count++;
    fetch_pc = 32'h113;
    #1;
    check_count++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h133) begin
      $display("[TB] FAIL alias_new: got %b/%h expected 1/00000133", pred_taken, pred_target);
    end else pass_count++;
  endtask

  task automatic test_wrap();
    do_resolve(1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 32'h1234);
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      $display("[TB] FAIL wrap_forced: got %b/%h expected 1/00000000", mispredict, redirect_pc);
    end else pass_count++;
    do_resolve(1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
    check_count++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
      $display("[TB] FAIL wrap_correct: got %b/%h expected 0/00000000", mispredict, redirect_pc);
    end else pass_count++;
  endtask

  task automatic test_back_to_back();
    resolve_valid = 1'b1;
    resolve_uncond = 1'b0;
    resolve_pc = 32'h200; resolve_taken = 1'b1; resolve_target = 32'h300;
    resolve_pred_taken = 1'b0; resolve_pred_target = 32'h0;
    @(posedge clock);
    #1;
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h300) begin
      $display("[TB] FAIL b2b_first: got %b/%h expected 1/00000300", mispredict, redirect_pc);
    end else pass_count++;
    resolve_pc = 32'h210; resolve_target = 32'h310;
    @(posedge clock);
    #1;
    resolve_valid = 1'b0;
    check_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h310) begin
      $display("[TB] FAIL b2b_second: got %b/%h expected 1/00000310", mispredict, redirect_pc);
    end else pass_count++;
    idle_cycle();
    check_count++;
    if (mispredict !== 1'b0) begin
      $display("[TB] FAIL b2b_end: got %b expected 0", mispredict);
    end else pass_count++;
  endtask

  task automatic test_mid_reset();
    resolve_valid = 1'b1;
    resolve_uncond = 1'b0;
    resolve_pc = 32'h300; resolve_taken = 1'b1; resolve_target = 32'h400;
    resolve_pred_taken = 1'b0; resolve_pred_target = 32'h0;
    #2;
    reset = 1'b0;
    #1;
    check_count++;
    if (mispredict !== 1'b0 || branch_count !== 16'h0 || mispredict_count !== 16'h0) begin
      $display("[TB] FAIL midreset_async: got %b %0d %0d expected 0 0 0", mispredict, branch_count, mispredict_count);
    end else pass_count++;
    @(posedge clock);
    #1;
    check_count++;
    if (mispredict !== 1'b0 || branch_count !== 16'h0) begin
      $display("[TB] FAIL midreset_held: got %b %0d expected 0 0", mispredict, branch_count);
    end else pass_count++;
    resolve_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    fetch_pc = 32'h20;
    #1;
    check_count++;
    if (pred_taken !== 1'b0) begin
      $display("[TB] FAIL midreset_entry20: got %b expected 0", pred_taken);
    end else pass_count++;
    fetch_pc = 32'h300;
    #1;
    check_count++;
    if (pred_taken !== 1'b0) begin
      $display("[TB] FAIL midreset_entry300: got %b expected 0", pred_taken);
    end else pass_count++;
    idle_cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      do_resolve(1'b0, 32'h500 + 32'(i), 1'b1, 32'h600, 1'b0, 32'h0);
    end
    check_count++;
    if (sm_branch_count !== 4'd15 || sm_mispredict_count !== 4'd15) begin
      $display("[TB] FAIL sat_small: got %0d/%0d expected 15/15", sm_branch_count, sm_mispredict_count);
    end else pass_count++;
    check_count++;
    if (branch_count !== 16'd20 || mispredict_count !== 16'd20) begin
      $display("[TB] FAIL sat_wide: got %0d/%0d expected 20/20", branch_count, mispredict_count);
    end else pass_count++;
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_allocate();
    test_hysteresis();
    test_jr_target();
    test_alias();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the processor's combinational branch/jump resolver.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, giving fetch a same-cycle taken/target prediction.
- Execute-stage resolution is compared against that prediction. On a miss, the block issues a registered mispredict/redirect pulse and keeps saturating performance counters.
- Sits between fetch (lookup port) and execute (resolve port). Pipeline flush logic consumes mispredict/redirect_pc.

Parameters:
- PC_WIDTH, 32, width of PC and target values.
- INDEX_BITS, 4, log2 of BTB depth; DEPTH = 2**INDEX_BITS entries.
- TAG_BITS, 12, tag width taken from pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS]; INDEX_BITS+TAG_BITS <= PC_WIDTH.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- fetch_pc  input  PC_WIDTH  PC being fetched this cycle.
- pred_taken  output  1  combinational prediction for fetch_pc.
- pred_target  output  PC_WIDTH  combinational predicted target; 0 when pred_taken=0.
- resolve_valid  input  1  execute stage holds a control-flow insn this cycle.
- resolve_uncond  input  1  insn is j/jal/jr (always taken); 0 for bne/blt/bex.
- resolve_pc  input  PC_WIDTH  PC of resolving insn.
- resolve_taken  input  1  actual direction.
- resolve_target  input  PC_WIDTH  actual target (jr: register value; bne/blt: PC+1+imm; j/jal/bex: zero-extended T).
- resolve_pred_taken  input  1  prediction carried down pipeline with insn.
- resolve_pred_target  input  PC_WIDTH  predicted target carried down pipeline.
- mispredict  output  1  registered one-cycle pulse.
- redirect_pc  output  PC_WIDTH  registered correct next PC; valid when mispredict=1.
- branch_count  output  CNT_WIDTH  resolved control-flow insns.
- mispredict_count  output  CNT_WIDTH  mispredictions.

Behaviour:

Reset (reset=0, async):
- All valid bits 0; counters 2'b01 (weakly not-taken); uncond bits 0.
- mispredict=0, redirect_pc=0, both perf counters 0.
- Reset asserted mid-operation discards any pending update/pulse immediately.

Lookup (combinational, zero latency):
- idx = fetch_pc[INDEX_BITS-1:0].
- hit = valid[idx] and tag[idx] matches.
- pred_taken = hit and (uncond[idx] or ctr[idx][1]).
- pred_target = pred_taken ? target[idx] : 0.

Resolution (on rising edge when resolve_valid=1):
- miss = (resolve_taken != resolve_pred_taken) or (resolve_taken and resolve_target != resolve_pred_target).
- mispredict <= miss.
- redirect_pc <= resolve_taken ? resolve_target : resolve_pc+1 (word-addressed PC, wraps modulo 2**PC_WIDTH).
- When resolve_valid=0: mispredict <= 0; redirect_pc holds its value.
- Latency: mispredict visible the cycle after resolve; it is high for exactly one cycle per miss.

BTB update (same edge), on entry ridx from resolve_pc:
- Entry hit (valid and tag match):
  - taken: ctr saturating increment (max 2'b11).
  - not taken: ctr saturating decrement (min 2'b00).
  - Target overwritten with resolve_target when taken (covers changing jr targets).
  - uncond <= resolve_uncond.
- Entry miss, taken: allocate (evicting any previous occupant). Set valid=1, tag, target=resolve_target, ctr=2'b10, uncond=resolve_uncond.
- Entry miss, not taken: no allocation, BTB unchanged.
- resolve_uncond=1 with resolve_taken=0 is illegal; the entry is treated as not taken, and verification flags it.

Simultaneous events:
- Same-cycle lookup and update of the same index: lookup returns the pre-edge contents (no bypass).

Performance counters:
- branch_count +1 per resolve_valid.
- mispredict_count +1 per miss.
- Both saturate at all-ones (no wrap).

Structure:
- Entries are flops (no RAM macro).
- Implementation targets ~200–300 lines.

Test Plan:
1. Reset, then fetch_pc=0x40 -> pred_taken=0, pred_target=0. Resolve bne at pc 0x40, taken, target 0x50, pred 0/0 -> next cycle mispredict=1, redirect_pc=0x50, mispredict_count=1. Then fetch 0x40 -> pred_taken=1, pred_target=0x50.
2. Counter hysteresis: after allocation (ctr=10), resolve 0x40 not-taken once -> ctr=01, pred_taken=0. Resolve taken twice -> ctr=11. Three not-takens -> ctr=00. A fourth not-taken stays at 00.
3. jr target change: entry 0x20 uncond, target 0x100. Resolve taken to 0x180 with pred 1/0x100 -> mispredict=1, redirect_pc=0x180. Lookup 0x20 then gives 0x180.
4. Alias eviction (INDEX_BITS=4): allocate pc 0x013, then resolve taken pc 0x113 -> lookup 0x013 misses (pred_taken=0), lookup 0x113 hits.
5. Not-taken correct prediction at pc 0xFFFFFFFF -> mispredict=0. Forced mispredict with pred_taken=1 -> redirect_pc=0x00000000 (wrap). Back-to-back resolves produce two consecutive single-cycle pulses.
6. Assert reset low mid-cycle while resolve_valid=1 with miss -> mispredict stays 0, all entries invalid, counters 0. Saturation: CNT_WIDTH=4, 20 resolves -> branch_count=15.
